// File: rtl/ex_mem_lane_reg_pkg.sv
// ---------------------------------------------------------------------------
// ex_mem_lane_reg_pkg
// Shared definitions for the EX/MEM multi-lane pipeline register.
//   - Per-lane payload field widths and bit offsets (LSB-relative)
//   - Derived per-lane payload width PAYLOAD_W_C
//   - Indices of the control bits inside the ctrl field
// Payload layout per lane, MSB to LSB:
//   ctrl[4:0] | zero | target[31:0] | alu[31:0] | store[31:0] | wreg[4:0]
// ---------------------------------------------------------------------------
package ex_mem_lane_reg_pkg;

  localparam int CTRL_W = 5;
  localparam int ZERO_W = 1;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam int PAYLOAD_W_C = CTRL_W + ZERO_W + 3 * DATA_W + REG_W;

  localparam int WREG_LSB   = 0;
  localparam int STORE_LSB  = WREG_LSB + REG_W;
  localparam int ALU_LSB    = STORE_LSB + DATA_W;
  localparam int TARGET_LSB = ALU_LSB + DATA_W;
  localparam int ZERO_LSB   = TARGET_LSB + DATA_W;
  localparam int CTRL_LSB   = ZERO_LSB + ZERO_W;

  // Bit positions inside the ctrl field
  typedef enum int {
    CTL_MEMTOREG = 0,
    CTL_REGWRITE = 1,
    CTL_MEMREAD  = 2,
    CTL_MEMWRITE = 3,
    CTL_BRANCH   = 4
  } ctrl_bit_e;

  // Field view of one lane payload; member order matches the offsets above
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              zero;
    logic [DATA_W-1:0] target;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] store;
    logic [REG_W-1:0]  wreg;
  } lane_payload_t;

endpackage

// File: rtl/ex_mem_lane_reg_pipe_entry.sv
// ---------------------------------------------------------------------------
// ex_mem_lane_reg_pipe_entry  (the pipe_entry storage element)
// One held entry of the EX/MEM register: valid bit, per-lane valid bits and
// the packed payload of all lanes.
// Next-state priority: clear > load > hold-with-mask.
// Ports:
//   clk            clock
//   clear_i        empty the entry (reset or group flush)
//   load_i         overwrite with load_lv_i / load_pl_i
//   load_lv_i      lane-valid bits to load
//   load_pl_i      payload to load (bubble lanes already zero)
//   mask_i         lanes to kill in the held contents when not loading
//   valid_o        stored valid
//   lane_valid_o   stored lane-valid bits
//   payload_o      stored payload
//   valid_m_o      valid after applying mask_i to the held contents
//   lane_valid_m_o lane-valid bits after applying mask_i
//   payload_m_o    payload with masked lanes zeroed
// ---------------------------------------------------------------------------
module ex_mem_lane_reg_pipe_entry
  import ex_mem_lane_reg_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int PAYLOAD_W = PAYLOAD_W_C
) (
  input  logic                         clk,
  input  logic                         clear_i,
  input  logic                         load_i,
  input  logic [LANES-1:0]             load_lv_i,
  input  logic [LANES*PAYLOAD_W-1:0]   load_pl_i,
  input  logic [LANES-1:0]             mask_i,
  output logic                         valid_o,
  output logic [LANES-1:0]             lane_valid_o,
  output logic [LANES*PAYLOAD_W-1:0]   payload_o,
  output logic                         valid_m_o,
  output logic [LANES-1:0]             lane_valid_m_o,
  output logic [LANES*PAYLOAD_W-1:0]   payload_m_o
);

  logic                       valid_q;
  logic                       valid_d;
  logic [LANES-1:0]           lv_q;
  logic [LANES-1:0]           lv_d;
  logic [LANES*PAYLOAD_W-1:0] pl_q;
  logic [LANES*PAYLOAD_W-1:0] pl_d;

  // Held contents with the masked lanes removed
  always_comb begin
    lane_valid_m_o = lv_q & ~mask_i;
    payload_m_o    = {LANES*PAYLOAD_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (mask_i[i]) begin
        payload_m_o[i*PAYLOAD_W +: PAYLOAD_W] = {PAYLOAD_W{1'b0}};
      end else begin
        payload_m_o[i*PAYLOAD_W +: PAYLOAD_W] = pl_q[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
    valid_m_o = valid_q & (|lane_valid_m_o);
  end

  // Next state; an entry is valid exactly when at least one lane survives
  always_comb begin
    if (clear_i) begin
      lv_d = {LANES{1'b0}};
      pl_d = {LANES*PAYLOAD_W{1'b0}};
    end else if (load_i) begin
      lv_d = load_lv_i;
      pl_d = load_pl_i;
    end else begin
      lv_d = lane_valid_m_o;
      pl_d = payload_m_o;
    end
    valid_d = |lv_d;
  end

  // Entry storage
  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    lv_q    <= lv_d;
    pl_q    <= pl_d;
  end

  assign valid_o      = valid_q;
  assign lane_valid_o = lv_q;
  assign payload_o    = pl_q;

endmodule

// File: rtl/ex_mem_lane_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_lane_reg
// Multi-lane EX/MEM pipeline register with valid/ready flow control and a
// 2-entry (head + skid) buffer so that in_ready comes straight from a flop
// and never depends combinationally on out_ready.
// Optional feature macro: EXMEM_PERF_CNT_EN (adds stall_cnt / bubble_cnt).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid              group valid from EX
//   in_lane_valid         per-lane valid within the group
//   in_payload            lane i at [i*PAYLOAD_W +: PAYLOAD_W]
//   in_ready              registered; high when the skid entry is free
//   out_valid             head entry valid to MEM (registered)
//   out_lane_valid        head lane-valid bits (registered)
//   out_payload           head payload (registered)
//   out_ready             MEM takes the head entry
//   flush                 kill all held and incoming entries
//   flush_lane_mask       kill selected lanes in all held entries
//   stall_cnt, bubble_cnt saturating perf counters (EXMEM_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module ex_mem_lane_reg
  import ex_mem_lane_reg_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int PAYLOAD_W = PAYLOAD_W_C
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [LANES-1:0]           in_lane_valid,
  input  logic [LANES*PAYLOAD_W-1:0] in_payload,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [LANES-1:0]           out_lane_valid,
  output logic [LANES*PAYLOAD_W-1:0] out_payload,
  input  logic                       out_ready,
  input  logic                       flush,
  input  logic [LANES-1:0]           flush_lane_mask
`ifdef EXMEM_PERF_CNT_EN
  ,
  output logic [31:0]                stall_cnt,
  output logic [31:0]                bubble_cnt
`endif
);

  localparam int W = LANES * PAYLOAD_W;

  logic             head_valid_q, head_valid_m_s;
  logic [LANES-1:0] head_lv_q, head_lv_m_s;
  logic [W-1:0]     head_pl_q, head_pl_m_s;
  logic             skid_valid_q, skid_valid_m_s;
  logic [LANES-1:0] skid_lv_q, skid_lv_m_s;
  logic [W-1:0]     skid_pl_q, skid_pl_m_s;

  logic             in_ready_q;
  logic             deq_s, acc_s, inc_s, clear_s;
  logic             keep_head_s, keep_skid_s;
  logic [LANES-1:0] inc_lv_s;
  logic [W-1:0]     inc_pl_s;
  logic             head_load_s, skid_load_s;
  logic [LANES-1:0] head_load_lv_s, skid_load_lv_s;
  logic [W-1:0]     head_load_pl_s, skid_load_pl_s;
  logic             skid_valid_next_s;
  logic             unused_s;

  // Handshakes and which held entries survive this edge
  always_comb begin
    deq_s       = head_valid_q & out_ready;
    acc_s       = in_valid & in_ready_q;
    inc_s       = acc_s & (|in_lane_valid);
    clear_s     = reset | flush;
    // A masked-out head is treated like a dequeued one so the skid compacts
    keep_head_s = head_valid_m_s & ~deq_s;
    keep_skid_s = skid_valid_m_s;
  end

  // Incoming group with bubble lanes forced to an all-zero payload
  always_comb begin
    inc_lv_s = in_lane_valid & {LANES{inc_s}};
    inc_pl_s = {W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (inc_lv_s[i]) begin
        inc_pl_s[i*PAYLOAD_W +: PAYLOAD_W] = in_payload[i*PAYLOAD_W +: PAYLOAD_W];
      end else begin
        inc_pl_s[i*PAYLOAD_W +: PAYLOAD_W] = {PAYLOAD_W{1'b0}};
      end
    end
  end

  // FIFO placement: survivors keep their order, the new group goes behind them
  always_comb begin
    head_load_s = ~keep_head_s;
    if (keep_skid_s) begin
      head_load_lv_s = skid_lv_m_s;
      head_load_pl_s = skid_pl_m_s;
    end else begin
      head_load_lv_s = inc_lv_s;
      head_load_pl_s = inc_pl_s;
    end
    skid_load_s = ~(keep_head_s & keep_skid_s);
    if (keep_head_s & ~keep_skid_s) begin
      skid_load_lv_s = inc_lv_s;
      skid_load_pl_s = inc_pl_s;
    end else begin
      skid_load_lv_s = {LANES{1'b0}};
      skid_load_pl_s = {W{1'b0}};
    end
    skid_valid_next_s = ~flush & keep_head_s & (keep_skid_s | inc_s);
  end

  ex_mem_lane_reg_pipe_entry #(
    .LANES     (LANES),
    .PAYLOAD_W (PAYLOAD_W)
  ) u_head (
    .clk            (clk),
    .clear_i        (clear_s),
    .load_i         (head_load_s),
    .load_lv_i      (head_load_lv_s),
    .load_pl_i      (head_load_pl_s),
    .mask_i         (flush_lane_mask),
    .valid_o        (head_valid_q),
    .lane_valid_o   (head_lv_q),
    .payload_o      (head_pl_q),
    .valid_m_o      (head_valid_m_s),
    .lane_valid_m_o (head_lv_m_s),
    .payload_m_o    (head_pl_m_s)
  );

  ex_mem_lane_reg_pipe_entry #(
    .LANES     (LANES),
    .PAYLOAD_W (PAYLOAD_W)
  ) u_skid (
    .clk            (clk),
    .clear_i        (clear_s),
    .load_i         (skid_load_s),
    .load_lv_i      (skid_load_lv_s),
    .load_pl_i      (skid_load_pl_s),
    .mask_i         (flush_lane_mask),
    .valid_o        (skid_valid_q),
    .lane_valid_o   (skid_lv_q),
    .payload_o      (skid_pl_q),
    .valid_m_o      (skid_valid_m_s),
    .lane_valid_m_o (skid_lv_m_s),
    .payload_m_o    (skid_pl_m_s)
  );

  // in_ready mirrors the next skid state so it is a pure flop output
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_q <= 1'b0;
    end else begin
      in_ready_q <= ~skid_valid_next_s;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = head_valid_q;
  assign out_lane_valid = head_lv_q;
  assign out_payload    = head_pl_q;

  assign unused_s = ^{head_lv_m_s, head_pl_m_s, skid_valid_q, skid_lv_q, skid_pl_q};

`ifdef EXMEM_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] bubble_cnt_q;

  // Saturating perf counters; flush intentionally leaves them untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (head_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
      if (!head_valid_q && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end else begin
        bubble_cnt_q <= bubble_cnt_q;
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_lane_reg.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_lane_reg
// Directed scenarios followed by random traffic, all checked against a
// queue-based reference model of the EX/MEM register.
// ---------------------------------------------------------------------------
module tb_ex_mem_lane_reg;

  localparam int L  = 2;
  localparam int PW = 107;
  localparam int W  = L * PW;

  typedef struct packed {
    logic [L-1:0] lv;
    logic [W-1:0] pl;
  } ent_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [L-1:0] in_lane_valid;
  logic [W-1:0] in_payload;
  logic         in_ready;
  logic         out_valid;
  logic [L-1:0] out_lane_valid;
  logic [W-1:0] out_payload;
  logic         out_ready;
  logic         flush;
  logic [L-1:0] flush_lane_mask;
`ifdef EXMEM_PERF_CNT_EN
  logic [31:0]  stall_cnt;
  logic [31:0]  bubble_cnt;
`endif

  always #5 clk = ~clk;

  ex_mem_lane_reg #(.LANES(L), .PAYLOAD_W(PW)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_lane_valid   (in_lane_valid),
    .in_payload      (in_payload),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_lane_valid  (out_lane_valid),
    .out_payload     (out_payload),
    .out_ready       (out_ready),
    .flush           (flush),
    .flush_lane_mask (flush_lane_mask)
`ifdef EXMEM_PERF_CNT_EN
    ,
    .stall_cnt       (stall_cnt),
    .bubble_cnt      (bubble_cnt)
`endif
  );

  // Reference model: queue of held groups, oldest first
  ent_t        mq[$];
  logic        mrdy;
  logic [31:0] mstall;
  logic [31:0] mbub;
  int          ck_total;
  int          ck_err;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    ck_total++;
    assert (obs === exp) else begin
      ck_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] rnd_lane();
    return PW'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  function automatic logic [W-1:0] rnd_group();
    logic [W-1:0] g;
    for (int i = 0; i < L; i++) g[i*PW +: PW] = rnd_lane();
    return g;
  endfunction

  // One clock: drive inputs, advance model at the edge, check 1 time unit later
  task automatic step(input logic iv, input logic [L-1:0] ilv, input logic [W-1:0] ipl,
                      input logic ordy, input logic fl, input logic [L-1:0] fm,
                      input logic rst);
    ent_t e;
    logic mov;
    reset = rst; in_valid = iv; in_lane_valid = ilv; in_payload = ipl;
    out_ready = ordy; flush = fl; flush_lane_mask = fm;
    @(posedge clk);
    mov = (mq.size() > 0);
    if (rst) begin
      mstall = 32'd0;
      mbub   = 32'd0;
    end else begin
      if (mov && !ordy && mstall != 32'hFFFF_FFFF) mstall = mstall + 32'd1;
      if (!mov && mbub != 32'hFFFF_FFFF) mbub = mbub + 32'd1;
    end
    if (rst) begin
      mq.delete();
      mrdy = 1'b0;
    end else if (fl) begin
      mq.delete();
      mrdy = 1'b1;
    end else begin
      if (mov && ordy) void'(mq.pop_front());
      for (int k = mq.size() - 1; k >= 0; k--) begin
        e = mq[k];
        for (int i = 0; i < L; i++) begin
          if (fm[i]) begin
            e.lv[i] = 1'b0;
            e.pl[i*PW +: PW] = {PW{1'b0}};
          end
        end
        if (e.lv == '0) mq.delete(k);
        else mq[k] = e;
      end
      if (iv && mrdy && (ilv != '0)) begin
        e.lv = ilv;
        e.pl = ipl;
        for (int i = 0; i < L; i++) if (!ilv[i]) e.pl[i*PW +: PW] = {PW{1'b0}};
        mq.push_back(e);
      end
      mrdy = (mq.size() < 2);
    end
    #1;
    chk("out_valid", W'(out_valid), W'(mq.size() > 0));
    chk("in_ready", W'(in_ready), W'(mrdy));
    if (mq.size() > 0) begin
      chk("out_lane_valid", W'(out_lane_valid), W'(mq[0].lv));
      chk("out_payload", out_payload, mq[0].pl);
    end else if (rst || fl) begin
      chk("cleared_lane_valid", W'(out_lane_valid), {W{1'b0}});
      chk("cleared_payload", out_payload, {W{1'b0}});
    end
`ifdef EXMEM_PERF_CNT_EN
    chk("stall_cnt", W'(stall_cnt), W'(mstall));
    chk("bubble_cnt", W'(bubble_cnt), W'(mbub));
`endif
  endtask

  logic [W-1:0] ga, gb, gc, gx;

  initial begin
    ck_total = 0; ck_err = 0; mrdy = 1'b0; mstall = 32'd0; mbub = 32'd0;
    ga = rnd_group(); gb = rnd_group(); gc = rnd_group(); gx = rnd_group();

    // Reset: in_ready low while asserted, outputs cleared
    repeat (3) step(1'b0, 2'b00, '0, 1'b1, 1'b0, 2'b00, 1'b1);
    step(1'b0, 2'b00, '0, 1'b1, 1'b0, 2'b00, 1'b0);

    // Back-to-back A,B,C with MEM always ready
    step(1'b1, 2'b11, ga, 1'b1, 1'b0, 2'b00, 1'b0);
    step(1'b1, 2'b11, gb, 1'b1, 1'b0, 2'b00, 1'b0);
    step(1'b1, 2'b11, gc, 1'b1, 1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, '0, 1'b1, 1'b0, 2'b00, 1'b0);

    // Stall: A in head, B in skid, then release
    step(1'b1, 2'b11, ga, 1'b0, 1'b0, 2'b00, 1'b0);
    step(1'b1, 2'b11, gb, 1'b0, 1'b0, 2'b00, 1'b0);
    step(1'b1, 2'b11, gc, 1'b0, 1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, '0, 1'b1, 1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, '0, 1'b1, 1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, '0, 1'b1, 1'b0, 2'b00, 1'b0);

    // Bubble lane squash: lane1 all ones but invalid
    step(1'b1, 2'b01, {{PW{1'b1}}, rnd_lane()}, 1'b0, 1'b0, 2'b00, 1'b0);
    chk("squash_lane1", W'(out_payload[PW +: PW]), {W{1'b0}});
    step(1'b1, 2'b00, rnd_group(), 1'b1, 1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, '0, 1'b1, 1'b0, 2'b00, 1'b0);

    // Lane mask on both entries, then single-lane head removed and skid compacts
    step(1'b1, 2'b11, ga, 1'b0, 1'b0, 2'b00, 1'b0);
    step(1'b1, 2'b11, gb, 1'b0, 1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, '0, 1'b0, 1'b0, 2'b10, 1'b0);
    step(1'b0, 2'b00, '0, 1'b1, 1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, '0, 1'b1, 1'b0, 2'b00, 1'b0);
    step(1'b1, 2'b01, gc, 1'b0, 1'b0, 2'b00, 1'b0);
    step(1'b1, 2'b10, gx, 1'b0, 1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, '0, 1'b0, 1'b0, 2'b01, 1'b0);
    step(1'b0, 2'b00, '0, 1'b0, 1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, '0, 1'b1, 1'b0, 2'b00, 1'b0);

    // Flush with both entries full and a group arriving
    step(1'b1, 2'b11, ga, 1'b0, 1'b0, 2'b00, 1'b0);
    step(1'b1, 2'b11, gb, 1'b0, 1'b0, 2'b00, 1'b0);
    step(1'b1, 2'b11, gx, 1'b0, 1'b1, 2'b00, 1'b0);
    step(1'b0, 2'b00, '0, 1'b1, 1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, '0, 1'b1, 1'b0, 2'b00, 1'b0);

    // Reset in the middle of a stall
    step(1'b1, 2'b11, ga, 1'b0, 1'b0, 2'b00, 1'b0);
    step(1'b1, 2'b11, gb, 1'b0, 1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, '0, 1'b0, 1'b0, 2'b00, 1'b1);
    step(1'b0, 2'b00, '0, 1'b1, 1'b0, 2'b00, 1'b0);

`ifdef EXMEM_PERF_CNT_EN
    // Three stalled cycles then two empty cycles
    step(1'b0, 2'b00, '0, 1'b0, 1'b0, 2'b00, 1'b1);
    step(1'b1, 2'b11, ga, 1'b0, 1'b0, 2'b00, 1'b0);
    repeat (3) step(1'b0, 2'b00, '0, 1'b0, 1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, '0, 1'b1, 1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, '0, 1'b1, 1'b0, 2'b00, 1'b0);
    // Saturation
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    force dut.bubble_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    release dut.bubble_cnt_q;
    mstall = 32'hFFFF_FFFF;
    mbub   = 32'hFFFF_FFFF;
    step(1'b0, 2'b00, '0, 1'b1, 1'b0, 2'b00, 1'b0);
    step(1'b1, 2'b11, gb, 1'b0, 1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, '0, 1'b0, 1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, '0, 1'b0, 1'b1, 2'b00, 1'b0);
`endif

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      logic         r_iv, r_ordy, r_fl, r_rst;
      logic [L-1:0] r_lv, r_fm;
      r_iv   = ($urandom_range(0, 9) < 7);
      r_lv   = L'($urandom_range(0, 3));
      r_ordy = ($urandom_range(0, 9) < 6);
      r_fl   = ($urandom_range(0, 39) == 0);
      r_fm   = ($urandom_range(0, 7) == 0) ? L'($urandom_range(1, 3)) : '0;
      r_rst  = ($urandom_range(0, 149) == 0);
      step(r_iv, r_lv, rnd_group(), r_ordy, r_fl, r_fm, r_rst);
    end
    repeat (3) step(1'b0, 2'b00, '0, 1'b1, 1'b0, 2'b00, 1'b0);

    $display("Result: errors=%0d of %0d checks", ck_err, ck_total);
    $finish;
  end

endmodule

// File: doc/ex_mem_lane_reg.md
# ex_mem_lane_reg

Parametrised, multi-lane EX/MEM pipeline register for the superscalar core with valid/ready flow control, a 2-entry skid buffer, and group and per-lane flush. It sits between the EX lanes and the MEM stage. It carries a packed per-lane payload (control bits, zero flag, branch target, ALU result, store data, destination register) plus per-lane valid bits. It allows MEM to stall without combinational ready paths back into EX.

## Interface
Parameters:
- LANES, 2, number of issue lanes (1..4)
- PAYLOAD_W, 107, bits per lane payload (5 ctrl + 1 zero + 32 target + 32 alu + 32 store + 5 wreg)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  group valid from EX
- in_lane_valid  in  LANES  per-lane valid within the group
- in_payload  in  LANES*PAYLOAD_W  lane i at bits [i*PAYLOAD_W +: PAYLOAD_W]
- in_ready  out  1  block can accept a group; registered
- out_valid  out  1  group valid to MEM
- out_lane_valid  out  LANES  per-lane valid of the head entry
- out_payload  out  LANES*PAYLOAD_W  head entry payload
- out_ready  in  1  MEM accepts head entry
- flush  in  1  kill all held and incoming entries
- flush_lane_mask  in  LANES  clear the selected lane-valid bits in every held entry
- stall_cnt  out  32  only with EXMEM_PERF_CNT_EN
- bubble_cnt  out  32  only with EXMEM_PERF_CNT_EN

## Operation
- Storage: a main entry (head) and a skid entry. Each entry holds a valid bit, LANES lane-valid bits and the payload.
- Accept: a group is accepted when in_valid && in_ready. in_ready = !skid.valid and is driven from a flop.
- Dequeue: the head entry dequeues when out_valid && out_ready.
- Placement of an accepted group:
  - Head empty, or head dequeuing with skid empty: goes to head.
  - Head held (not dequeuing): goes to skid.
- On dequeue with skid full, skid moves to head. Ordering is strictly FIFO.
- Bubble squash on capture: a lane with in_lane_valid=0 stores an all-zero payload. This guarantees RegWrite/MemWrite = 0 for that lane. A group with in_valid=1 but all lane-valid bits 0 is accepted and stored with valid=0, so it is never presented.
- flush_lane_mask: in the same edge, clears the masked lane-valid bits and zeroes those lanes' payloads in head and skid. An entry whose lane-valid bits become all zero drops its valid bit, and the skid compacts into head.
- flush: all entries are invalidated and lane-valid bits and payloads are cleared. Any simultaneous input is dropped. flush has priority over the mask, over accept and over dequeue. A dequeue in the flush cycle still completes, because MEM sampled the head entry.
- Reset:
  - Registered outputs: out_valid=0, out_lane_valid=0, out_payload=0, in_ready=1 from the first cycle after reset; the counters are 0.
  - While reset is asserted, in_ready=0.
  - Reset asserted mid-stall discards both entries.

## Timing
- Latency: 1 cycle from accept to out_valid when head is empty.
- Throughput: 1 group per cycle while out_ready=1.
- in_ready falls in the cycle after the skid is filled. It rises in the cycle after the skid drains into head.
- No combinational path from out_ready to in_ready.
- Simultaneous accept and dequeue with the skid full cannot occur, because in_ready=0.
- flush_lane_mask takes effect at the next edge. out_lane_valid reflects it one cycle later.

## Configuration
- EXMEM_PERF_CNT_EN defined:
  - stall_cnt increments on each cycle with out_valid && !out_ready.
  - bubble_cnt increments on each cycle with !out_valid.
  - Both counters are 32-bit, saturate at 0xFFFFFFFF, are cleared by reset and are not affected by flush.
- EXMEM_PERF_CNT_EN undefined: the ports and counter logic are absent.

## Structure
- Shared package:
  - Payload field offsets and widths (CTRL_W=5, DATA_W=32, REG_W=5).
  - PAYLOAD_W derivation.
  - Control-bit indices: MemToReg, RegWrite, MemRead, MemWrite, Branch.
- One sub-module, pipe_entry, holds one entry (valid, lane-valid, payload) with load, mask-clear and clear controls. It is instantiated twice (head and skid).

## Test plan
- LANES=2, out_ready=1, groups A,B,C on consecutive cycles: out_valid from cycle 1, payloads A,B,C in order, in_ready stays 1.
- Hold out_ready=0 while sending A,B: A in head, B in skid, in_ready=0 next cycle. Release: A then B, and in_ready=1 one cycle after B reaches head.
- in_lane_valid=2'b01 with lane1 payload all 1s: out_lane_valid=01 and lane1 out_payload=0.
- Head A with lanes 11, skid B with lanes 11, flush_lane_mask=2'b10: both entries show lanes 01 next cycle. Then mask 2'b01 on a single-lane entry: the entry disappears and skid compacts to head.
- flush while in_valid=1 and both entries full: out_valid=0 and in_ready=1 next cycle, and the incoming group is never seen.
- With EXMEM_PERF_CNT_EN: 3 stalled cycles plus 2 empty cycles gives stall_cnt=3 and bubble_cnt=2. Preloading the counters to saturation holds them at 0xFFFFFFFF.
